// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter between the load/store
// unit (port 0) and the debug/loader port (port 1).
package dmem_arb_pkg;

    typedef enum logic {
        ARB_NORM = 1'b0,
        ARB_AGED = 1'b1
    } arb_state_e;

    localparam int PORT_CORE = 0;
    localparam int PORT_DBG  = 1;

    localparam int DEF_ADDR_W   = 32;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_STRB_W   = DEF_DATA_W / 8;
    localparam int DEF_MAX_WAIT = 8;

    // Bits needed to hold the values 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/dmem_arb_age_ctr.sv
// Starvation guard for port 1: saturating wait counter plus NORM/AGED state.
// 'aged' hands priority to port 1 until it is granted or withdraws its request.
module dmem_arb_age_ctr
    import dmem_arb_pkg::*;
#(
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic p1_req,
    input  logic p1_gnt,
    output logic aged
);

    localparam int                CNT_W   = cnt_width(MAX_WAIT);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0]  CNT_AGE = CNT_W'(MAX_WAIT - 1);

    arb_state_e       state;
    logic [CNT_W-1:0] wait_cnt;
    logic             starved;

    assign starved = p1_req && !p1_gnt;

    // NOTE: state updates use non-blocking assignments so every register in this
    // block samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ARB_NORM;
            wait_cnt <= '0;
        end else begin
            if (!starved)
                wait_cnt <= '0;
            else if (wait_cnt != CNT_MAX)
                wait_cnt <= wait_cnt + 1'b1;

            case (state)
                ARB_NORM: if (starved && wait_cnt == CNT_AGE) state <= ARB_AGED;
                ARB_AGED: if (p1_gnt || !p1_req)              state <= ARB_NORM;
                default:                                      state <= ARB_NORM;
            endcase
        end
    end

    assign aged = (state == ARB_AGED);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the synchronous-read data_mem; port 0 has fixed
// priority with aging for port 1. Define DMEM_ARB_RR_EN for strict round-robin.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int STRB_W   = DEF_STRB_W,
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic [STRB_W-1:0] p0_wstrb,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,

    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    input  logic [STRB_W-1:0] p1_wstrb,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,

    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [STRB_W-1:0] mem_wstrb,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic OWN_CORE = 1'(PORT_CORE);
    localparam logic OWN_DBG  = 1'(PORT_DBG);

    logic p0_first;   // port 0 wins if both request this cycle

`ifdef DMEM_ARB_RR_EN
    logic last_gnt;   // index of the port granted most recently

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_gnt <= OWN_DBG;
        else if (p0_gnt)
            last_gnt <= OWN_CORE;
        else if (p1_gnt)
            last_gnt <= OWN_DBG;
    end

    assign p0_first = (last_gnt == OWN_DBG);
`else
    logic aged;

    dmem_arb_age_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_age_ctr (
        .clk    (clk),
        .rst_n  (rst_n),
        .p1_req (p1_req),
        .p1_gnt (p1_gnt),
        .aged   (aged)
    );

    assign p0_first = !aged;
`endif

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the if/else leaves a signal unassigned and infers a latch.
    always_comb begin
        p0_gnt = 1'b0;
        p1_gnt = 1'b0;
        if (rst_n) begin
            if (p0_req && (p0_first || !p1_req))
                p0_gnt = 1'b1;
            else if (p1_req)
                p1_gnt = 1'b1;
        end
    end

    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic              any_gnt;

    assign any_gnt  = p0_gnt || p1_gnt;
    assign sel_we   = p1_gnt ? p1_we   : p0_we;
    assign sel_addr = p1_gnt ? p1_addr : p0_addr;

    always_comb begin
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_raddr = '0;
        mem_waddr = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        if (any_gnt) begin
            if (sel_we) begin
                mem_we    = 1'b1;
                mem_waddr = sel_addr;
                mem_wdata = p1_gnt ? p1_wdata : p0_wdata;
                mem_wstrb = p1_gnt ? p1_wstrb : p0_wstrb;
            end else begin
                mem_re    = 1'b1;
                mem_raddr = sel_addr;
            end
        end
    end

    // Read return: one pending slot is enough because data_mem answers next cycle.
    logic rd_pending;
    logic rd_owner;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pending <= 1'b0;
            rd_owner   <= OWN_CORE;
        end else begin
            rd_pending <= mem_re;
            if (mem_re)
                rd_owner <= p1_gnt ? OWN_DBG : OWN_CORE;
        end
    end

    assign p0_rvalid = rd_pending && (rd_owner == OWN_CORE);
    assign p1_rvalid = rd_pending && (rd_owner == OWN_DBG);
    assign p0_rdata  = mem_rdata;
    assign p1_rdata  = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed stimulus pushes expected read data,
// a negedge monitor pops it when rvalid appears and checks data and latency.
module tb_dmem_arbiter;

    localparam int MAX_WAIT = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic [3:0]  p0_wstrb, p1_wstrb;
    logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
    logic [31:0] p0_rdata, p1_rdata;
    logic        mem_re, mem_we;
    logic [31:0] mem_raddr, mem_waddr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    dmem_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .p0_req    (p0_req),
        .p0_we     (p0_we),
        .p0_addr   (p0_addr),
        .p0_wdata  (p0_wdata),
        .p0_wstrb  (p0_wstrb),
        .p0_gnt    (p0_gnt),
        .p0_rvalid (p0_rvalid),
        .p0_rdata  (p0_rdata),
        .p1_req    (p1_req),
        .p1_we     (p1_we),
        .p1_addr   (p1_addr),
        .p1_wdata  (p1_wdata),
        .p1_wstrb  (p1_wstrb),
        .p1_gnt    (p1_gnt),
        .p1_rvalid (p1_rvalid),
        .p1_rdata  (p1_rdata),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_raddr (mem_raddr),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural data_mem: byte-strobed write, one-cycle synchronous read.
    logic [31:0] mem [0:63];
    always @(posedge clk) begin
        if (!rst_n) begin
            mem[0] <= 32'hCAFE_0000;
            mem[1] <= 32'hCAFE_0004;
            mem[4] <= 32'h0000_0000;
            mem[8] <= 32'h1122_3344;
        end else begin
            if (mem_we)
                for (int b = 0; b < 4; b++)
                    if (mem_wstrb[b]) mem[mem_waddr[7:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            if (mem_re)
                mem_rdata <= mem[mem_raddr[7:2]];
        end
    end

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    int   cyc = 0;
    int   passed = 0;
    int   total = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every rvalid must match the oldest expected read and arrive on time.
    always @(negedge clk) begin
        if (rst_n) begin
            if (p0_rvalid) begin
                if (q0.size() == 0) check("p0_rvalid spurious", p0_rvalid, 1'b0);
                else begin
                    e0 = q0.pop_front();
                    check("p0_rdata", p0_rdata, e0.data);
                    check("p0_rvalid cycle", cyc, e0.due);
                end
            end else if (q0.size() != 0 && q0[0].due <= cyc) begin
                check("p0_rvalid missing", p0_rvalid, 1'b1);
                void'(q0.pop_front());
            end
            if (p1_rvalid) begin
                if (q1.size() == 0) check("p1_rvalid spurious", p1_rvalid, 1'b0);
                else begin
                    e1 = q1.pop_front();
                    check("p1_rdata", p1_rdata, e1.data);
                    check("p1_rvalid cycle", cyc, e1.due);
                end
            end else if (q1.size() != 0 && q1[0].due <= cyc) begin
                check("p1_rvalid missing", p1_rvalid, 1'b1);
                void'(q1.pop_front());
            end
        end
    end

    task automatic set_p0(input logic req, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb);
        p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata; p0_wstrb = strb;
    endtask

    task automatic set_p1(input logic req, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb);
        p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_wstrb = strb;
    endtask

    // One clock: check grants at negedge, queue expected read data, return at posedge+1.
    task automatic step(input string tag, input logic g0, input logic g1,
                        input logic [31:0] d0, input logic [31:0] d1);
        @(negedge clk);
        check({tag, " p0_gnt"}, p0_gnt, g0);
        check({tag, " p1_gnt"}, p1_gnt, g1);
        if (g0 && !p0_we) q0.push_back('{data: d0, due: cyc + 1});
        if (g1 && !p1_we) q1.push_back('{data: d1, due: cyc + 1});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_p0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_p1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        q0.delete();
        q1.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, with requests high so the gating is exercised.
        rst_n = 1'b0;
        set_p0(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        set_p1(1'b1, 1'b1, 32'h4, 32'h0, 4'hF);
        #2;
        check("reset p0_gnt", p0_gnt, 1'b0);
        check("reset p1_gnt", p1_gnt, 1'b0);
        check("reset mem_re", mem_re, 1'b0);
        check("reset mem_we", mem_we, 1'b0);
        check("reset p0_rvalid", p0_rvalid, 1'b0);
        check("reset p1_rvalid", p1_rvalid, 1'b0);
        do_reset();

        // Idle: no grant, all memory outputs zero.
        step("idle", 1'b0, 1'b0, 32'h0, 32'h0);
        check("idle mem_raddr", mem_raddr, 32'h0);
        check("idle mem_wdata", mem_wdata, 32'h0);

        // 1: port 0 write then read of 0x10.
        set_p0(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
        #1;
        check("t1 mem_we", mem_we, 1'b1);
        check("t1 mem_waddr", mem_waddr, 32'h10);
        check("t1 mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        check("t1 mem_wstrb", mem_wstrb, 4'hF);
        step("t1 write", 1'b1, 1'b0, 32'h0, 32'h0);
        set_p0(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        #1;
        check("t1 mem_re", mem_re, 1'b1);
        check("t1 mem_raddr", mem_raddr, 32'h10);
        step("t1 read", 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0);
        set_p0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        step("t1 drain", 1'b0, 1'b0, 32'h0, 32'h0);

`ifndef DMEM_ARB_RR_EN
        // 2: continuous contention; port 1 is force-granted on cycle MAX_WAIT+1.
        set_p0(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        set_p1(1'b1, 1'b0, 32'h4, 32'h0, 4'h0);
        for (int k = 1; k <= MAX_WAIT; k++)
            step("t2 contend", 1'b1, 1'b0, 32'hCAFE_0000, 32'h0);
        step("t2 aged", 1'b0, 1'b1, 32'h0, 32'hCAFE_0004);
        set_p1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        step("t2 back", 1'b1, 1'b0, 32'hCAFE_0000, 32'h0);
        set_p0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        step("t2 drain", 1'b0, 1'b0, 32'h0, 32'h0);
`endif

        // 3: same-cycle read (p0) and byte write (p1) to 0x20.
        do_reset();
        set_p0(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
        set_p1(1'b1, 1'b1, 32'h20, 32'h0000_00AA, 4'b0001);
        step("t3 conflict", 1'b1, 1'b0, 32'h1122_3344, 32'h0);
        set_p0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        step("t3 p1 write", 1'b0, 1'b1, 32'h0, 32'h0);
        set_p1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_p0(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
        step("t3 reread", 1'b1, 1'b0, 32'h1122_33AA, 32'h0);

        // 4: back-to-back reads return in order.
        set_p0(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        step("t4 rd0", 1'b1, 1'b0, 32'hCAFE_0000, 32'h0);
        set_p0(1'b1, 1'b0, 32'h4, 32'h0, 4'h0);
        step("t4 rd4", 1'b1, 1'b0, 32'hCAFE_0004, 32'h0);
        set_p0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        step("t4 drain", 1'b0, 1'b0, 32'h0, 32'h0);
        step("t4 idle", 1'b0, 1'b0, 32'h0, 32'h0);

`ifndef DMEM_ARB_RR_EN
        // 5: reset during a read return, part-way through contention.
        set_p0(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        set_p1(1'b1, 1'b0, 32'h4, 32'h0, 4'h0);
        for (int k = 1; k <= 5; k++)
            step("t5 contend", 1'b1, 1'b0, 32'hCAFE_0000, 32'h0);
        #1;
        check("t5 pre-reset p0_rvalid", p0_rvalid, 1'b1);
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        #1;
        check("t5 p0_rvalid", p0_rvalid, 1'b0);
        check("t5 p1_rvalid", p1_rvalid, 1'b0);
        check("t5 p0_gnt", p0_gnt, 1'b0);
        check("t5 p1_gnt", p1_gnt, 1'b0);
        check("t5 mem_re", mem_re, 1'b0);
        check("t5 mem_we", mem_we, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 1; k <= MAX_WAIT; k++)
            step("t5 after", 1'b1, 1'b0, 32'hCAFE_0000, 32'h0);
        step("t5 aged", 1'b0, 1'b1, 32'h0, 32'hCAFE_0004);
        set_p0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_p1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        step("t5 drain", 1'b0, 1'b0, 32'h0, 32'h0);
`else
        // 6: round-robin alternation under contention.
        do_reset();
        set_p0(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        set_p1(1'b1, 1'b0, 32'h4, 32'h0, 4'h0);
        step("t6 c1", 1'b1, 1'b0, 32'hCAFE_0000, 32'h0);
        step("t6 c2", 1'b0, 1'b1, 32'h0, 32'hCAFE_0004);
        step("t6 c3", 1'b1, 1'b0, 32'hCAFE_0000, 32'h0);
        step("t6 c4", 1'b0, 1'b1, 32'h0, 32'hCAFE_0004);
        set_p0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_p1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        step("t6 drain", 1'b0, 1'b0, 32'h0, 32'h0);
`endif

        step("final", 1'b0, 1'b0, 32'h0, 32'h0);
        check("p0 queue empty", q0.size(), 32'd0);
        check("p1 queue empty", q1.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-port arbiter that shares the single synchronous-read data_mem between the pipeline load/store unit (port 0) and the debug/loader port (port 1). It issues at most one memory access per cycle and routes the next-cycle read data back to the requester that issued the read. Port 0 has fixed priority. An aging counter stops port 1 from being starved. The block sits between the MEM/WB stage and data_mem.

Parameters:
ADDR_W, 32, byte-address width
DATA_W, 32, data width
STRB_W, 4, byte-strobe width (DATA_W/8)
MAX_WAIT, 8, cycles port 1 may wait before it is force-granted (must be >= 1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous reset, active low
p0_req / p1_req  in  1  request, held stable until granted
p0_we / p1_we  in  1  1 = write, 0 = read
p0_addr / p1_addr  in  ADDR_W  byte address
p0_wdata / p1_wdata  in  DATA_W  write data
p0_wstrb / p1_wstrb  in  STRB_W  byte enables
p0_gnt / p1_gnt  out  1  combinational grant; req && gnt = transfer accepted this cycle
p0_rvalid / p1_rvalid  out  1  read data valid, registered
p0_rdata / p1_rdata  out  DATA_W  read data (mem_rdata passthrough)
mem_re, mem_we  out  1  to data_mem
mem_raddr, mem_waddr  out  ADDR_W  to data_mem
mem_wdata  out  DATA_W  to data_mem
mem_wstrb  out  STRB_W  to data_mem
mem_rdata  in  DATA_W  from data_mem, valid one cycle after mem_re

Behaviour:
- Reset: rst_n low immediately clears state to NORM, wait_cnt to 0, both rvalid to 0 and rd_owner to 0.
- While rst_n is low, both gnt outputs, mem_re and mem_we are 0.
- At most one gnt is high per cycle. A gnt is asserted only when the matching req is high.
- FSM states:
  - NORM: p0_gnt = p0_req; p1_gnt = p1_req && !p0_req.
  - AGED: p1_gnt = p1_req; p0_gnt = p0_req && !p1_req.
- wait_cnt: increments each cycle that p1_req && !p1_gnt, saturating at MAX_WAIT. It clears when p1 is granted or when p1_req is low.
- Transitions:
  - NORM -> AGED on the clock edge where wait_cnt == MAX_WAIT-1 and p1 is still not granted. Port 1 is therefore granted on the (MAX_WAIT+1)th cycle of continuous contention.
  - AGED -> NORM on a p1 grant, or when p1_req is low.
- Memory drive:
  - Granted read: mem_re = 1, mem_raddr = addr.
  - Granted write: mem_we = 1, mem_waddr/wdata/wstrb from the granted port.
  - When not granted, all mem_* outputs are 0.
- Read return:
  - rd_owner is registered at the read accept. rvalid of that port rises in the cycle after the accept, for exactly 1 cycle per accepted read.
  - prdata of both ports = mem_rdata. Only the owning port's rvalid qualifies it.
  - Back-to-back reads give consecutive rvalid pulses in issue order.
- Writes get no response; the accept cycle is the completion. Data written in cycle N is visible to a read accepted in cycle N+1 or later.
- Simultaneous read and write from different ports: only one is granted, per priority. There is no reordering.
- Reset mid-read: a pending rvalid is dropped. The requester must reissue the read.

Optional Feature:
DMEM_ARB_RR_EN
- Defined: strict round-robin. A last_gnt register is reset to 1, so port 0 wins the first conflict. Under contention the grant goes to the port not granted last. The aging FSM and wait_cnt are not built, and MAX_WAIT is ignored.
- Undefined: fixed priority with aging, as described in Behaviour.

Decomposition:
- Package dmem_arb_pkg holds:
  - the state encoding (ARB_NORM = 1'b0, ARB_AGED = 1'b1);
  - port index constants (PORT_CORE = 0, PORT_DBG = 1);
  - default widths.
- One sub-module, dmem_arb_age_ctr, holds the saturating wait counter and NORM/AGED FSM. Its inputs are p1 req/gnt; its output is the aged flag. It is omitted when DMEM_ARB_RR_EN is defined.

Test Plan:
1. Port 0 writes 0xDEADBEEF to 0x10 with wstrb 1111, then reads 0x10 -> p0_gnt in the same cycle as each req; p0_rvalid = 1 one cycle after the read accept with p0_rdata = 0xDEADBEEF; p1_rvalid stays 0.
2. Both ports request reads continuously, MAX_WAIT = 8 -> p0 granted cycles 1-8, p1 granted cycle 9, p0 granted again cycle 10; p1_rvalid pulses in cycle 10.
3. Word 0x20 holds 0x11223344. Same cycle: p0 reads 0x20 while p1 writes 0x000000AA with wstrb 0001 -> p0 returns 0x11223344; p1 granted next cycle; a later p0 read returns 0x112233AA.
4. p0 reads 0x0 then 0x4 on back-to-back cycles -> p0_rvalid high for 2 consecutive cycles, data in order 0x0 then 0x4.
5. rst_n pulled low in the cycle after a read accept -> rvalid, gnt, mem_re and mem_we drop to 0 asynchronously; after release the state is NORM and the first conflict is won by p0.
6. With DMEM_ARB_RR_EN, both ports request for 4 cycles -> grants go p0, p1, p0, p1.
